rv_mdu: RTL and testbench
=========================

RV_MDU -- requirements
Module: rv_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values are even numbers 8..64.
REQ-002 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_n  in  1  reset, asynchronous assert and active-low; deassertion is synchronised externally.
REQ-004 Port start  in  1  request; sampled only when busy=0.
REQ-005 Port op  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port a, b  in  WIDTH each  operands (rs1, rs2), captured at start acceptance.
REQ-007 Port flush  in  1  synchronous abort of an in-flight operation.
REQ-008 Port busy  out  1  high in RUN and FIN.
REQ-009 Port done  out  1  one-cycle pulse; result valid.
REQ-010 Port result  out  WIDTH  registered result, held until the next accepted start.
REQ-011 Port Zero  out  1  result == 0, combinational from the result register.

Function
REQ-012 States SHALL be IDLE, RUN, FIN and DONE; busy=1 only in RUN and FIN; done=1 only in DONE.
REQ-013 Start is accepted on an edge where start=1 and state is IDLE or DONE; a, b and op are latched and the bit counter is cleared; start while busy=1 is ignored with no queueing.
REQ-014 Accepted normal op: IDLE/DONE->RUN; RUN lasts exactly WIDTH cycles, processing one bit per cycle; RUN->FIN; FIN->DONE; DONE->IDLE unless a new start is accepted.
REQ-015 Latency: start sampled at edge E0 gives done high in the cycle after edge E0+WIDTH+1, i.e. 33 cycles for WIDTH=32.
REQ-016 Multiply: shift-add on operand magnitudes with a 2*WIDTH product. Sign handling: MULH signed x signed; MULHSU signed a x unsigned b; MULHU and MUL unsigned. Product negation is applied in FIN.
REQ-017 MUL returns product[WIDTH-1:0]; MULH, MULHSU and MULHU return product[2*WIDTH-1:WIDTH].
REQ-018 Divide: restoring division on magnitudes. Quotient sign = sign(a) XOR sign(b) for DIV; remainder sign = sign(a) for REM; corrections are applied in FIN.
REQ-019 Division by zero SHALL bypass RUN, going IDLE/DONE->DONE at E0 with done in the next cycle:
- DIV and DIVU return all-ones.
- REM and REMU return a.
REQ-020 Signed overflow (DIV/REM with a = minimum negative value and b = all-ones) SHALL bypass RUN the same way: DIV returns a, REM returns 0.
REQ-021 flush=1 in RUN or FIN returns to IDLE on that edge with no done and result unchanged; flush has priority over start; flush in IDLE or DONE forces IDLE.
REQ-022 Zero SHALL track the result register at all times, including after reset.

Reset
REQ-023 rst_n=0 immediately (asynchronously) forces state IDLE, busy=0, done=0, result=0 (so Zero=1), and clears the counter and internal accumulators.
REQ-024 Reset mid-operation discards the operation; no done is produced after release.
REQ-025 The first start is accepted on the first rising edge with rst_n=1.

Verification (WIDTH=32)
REQ-026 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 cycles after the start edge; busy high for 32+1 cycles.
REQ-027 MULH a=b=0x80000000 -> result 0x40000000; MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> result 0xFFFFFFFF.
REQ-028 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-029 DIVU a=5, b=0 -> 0xFFFFFFFF with done 1 cycle after start; REM a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0 with Zero=1.
REQ-030 flush pulsed at RUN cycle 10 -> busy drops next cycle, no done, result keeps its prior value; a start on the following cycle completes normally.
REQ-031 rst_n low for 1 cycle at RUN cycle 5 -> outputs are 0 asynchronously (Zero=1) and no done is ever produced; a start held during busy is ignored (no second done).

Source files
------------

// File: rtl/rv_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit: one operand bit per cycle,
// with sign fix-up in FIN and fast paths for divide-by-zero and signed overflow.
module rv_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Zero
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one shift-add / restoring-divide step per cycle, WIDTH cycles
  // FIN   | sign correction and result selection
  // DONE  | result valid, done pulse; may accept a new start
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             a_neg, b_neg, start_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, bypass;
  logic [WIDTH-1:0] bypass_res;

  always_comb begin
    a_neg     = a[WIDTH-1] & ((op == OP_MULH) | (op == OP_MULHSU) |
                              (op == OP_DIV)  | (op == OP_REM));
    b_neg     = b[WIDTH-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    start_neg = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero  = op[2] & (b == '0);
    div_ovf   = ((op == OP_DIV) | (op == OP_REM)) & (a == MIN_NEG) & (b == '1);
    bypass    = div_zero | div_ovf;
    if (div_zero) bypass_res = op[1] ? a : '1;
    else          bypass_res = op[1] ? '0 : a;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rs;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fin_res;

  // The low half of {hi,lo} doubles as multiplier (mul) or dividend/quotient (div).
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : {(WIDTH+1){1'b0}});
    div_rs   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = (div_rs >= {1'b0, md_q});
    div_diff = div_rs - {1'b0, md_q};
  end

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:                      fin_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fin_res = quo_fix;
      default:                     fin_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      md_q    <= md_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    md_d    = md_q;
    res_d   = res_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            op_d  = op;
            neg_d = start_neg;
            cnt_d = '0;
            hi_d  = '0;
            md_d  = op[2] ? b_mag : a_mag;
            lo_d  = op[2] ? a_mag : b_mag;
            if (bypass) begin
              res_d   = bypass_res;
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (op_q[2]) begin
            hi_d = div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_d = S_FIN;
        end
        S_FIN: begin
          res_d   = fin_res;
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy   = (state_q == S_RUN) || (state_q == S_FIN);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign Zero   = (res_q == '0);

endmodule

// File: tb/tb_rv_mdu.sv
// Bench for rv_mdu (WIDTH=32): transaction-level reference model checked every
// cycle, literal directed cases, and randomized start/flush/operand traffic.
module tb_rv_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0;
  logic        busy, done, Zero;
  logic [31:0] result;

  rv_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result), .Zero(Zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // RISC-V M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit ref_bypass(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Model: an accepted normal op finishes 33 edges later; a bypass op is done at once.
  bit          m_busy, m_done;
  int          m_left;
  logic [31:0] m_res, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0; m_res = '0; m_pend = '0;
    end else begin
      m_done = 0;
      if (flush) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_res = m_pend;
        end
      end else if (start) begin
        if (ref_bypass(op, a, b)) begin
          m_res = ref_res(op, a, b); m_done = 1;
        end else begin
          m_pend = ref_res(op, a, b); m_busy = 1; m_left = 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("result", result, m_res);
      chk("Zero", Zero, m_res == 0);
    end
  end

  // Issues one op, then checks the literal result, done-edge offset and busy length.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r, input int exp_off, input string nm);
    int e0, off, bcnt;
    bit seen;
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    e0 = cyc; start = 0;
    bcnt = 0; seen = 0; off = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) begin
        seen = 1; off = cyc - e0;
      end else begin
        if (busy) bcnt++;
        @(negedge clk);
      end
    end
    chk({nm, " done_seen"}, seen, 1);
    chk({nm, " result"}, result, exp_r);
    chk({nm, " done_offset"}, off, exp_off);
    chk({nm, " busy_cycles"}, bcnt, (exp_off == 0) ? 0 : 33);
    chk({nm, " Zero"}, Zero, exp_r == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount, pre_res, sel;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset Zero", Zero, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1; chk_en = 1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, "MULHSU");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "REMU");
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "DIVU0");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 0, "REM0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "DIVOVF");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, "REMOVF");
    run_op(3'd5, 32'd77, 32'd7, 32'd11, 33, "DIVU2");

    // Flush at RUN cycle 10.
    pre_res = result;
    @(negedge clk);
    start = 1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush busy", busy, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("flush no_done", dcount, 0);
    chk("flush result_kept", result, pre_res);
    run_op(3'd0, 32'd3, 32'd5, 32'd15, 33, "MUL_after_flush");

    // Reset at RUN cycle 5.
    @(negedge clk);
    start = 1; op = 3'd3; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst result", result, 0);
    chk("arst Zero", Zero, 1);
    @(negedge clk);
    rst_n = 1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("arst no_done", dcount, 0);

    // Start held high while busy must not queue a second op.
    start = 1; op = 3'd5; a = 32'd100; b = 32'd7;
    for (int i = 0; i < 20; i++) @(negedge clk);
    start = 0;
    dcount = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("held_start done_count", dcount, 1);
    chk("held_start result", result, 32'd14);

    // Random traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 59) == 0);
      op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      case (sel)
        0: begin a = $urandom; b = 32'h0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(0, 20)); end
        3: begin a = -32'($urandom_range(0, 300)); b = -32'($urandom_range(1, 20)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      @(negedge clk);
    end
    start = 0; flush = 0;
    for (int i = 0; i < 40; i++) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
